// File: rtl/fast_fifo_stream_reader_pkg.sv
// Shared constants and helpers for FastFIFO read-side consumers.
// Holds the credit-width rule, the read-latency helper and the per-cycle event bundle.
package fast_fifo_stream_reader_pkg;

  localparam int MAX_READ_LATENCY = 15;

  // Credits must be able to hold the full buffer count, so one bit more than the pointer.
  function automatic int READER_CREDIT_W(input int depthLog2);
    return depthLog2 + 1;
  endfunction

  function automatic int fastFifoReadLatency(input bit isMlab, input int readAddrStages);
    return readAddrStages + (isMlab ? 0 : 2);
  endfunction

  typedef struct packed {
    logic request;
    logic transfer;
    logic slotFree;
    logic bufFull;
    logic drop;
    logic write;
    logic bypass;
    logic memWrite;
    logic memLoad;
    logic creditRelease;
  } readerEvents_t;

endpackage

// File: rtl/fast_fifo_stream_reader_tracker.sv
// read_inflight_tracker: delays each issued read by LATENCY cycles so it lines up with
// the FIFO's returning valid; flags rejected reads (release) and unrequested data.
module read_inflight_tracker #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic dataValid,
  output logic tapIssued,
  output logic releaseCredit,
  output logic unmatchedValid
);

  generate
    if (LATENCY == 0) begin : gen_bypass
      assign tapIssued = issue;
    end else if (LATENCY == 1) begin : gen_single
      logic issuedQ;
      always_ff @(posedge clk) begin
        if (rst) issuedQ <= 1'b0;
        else     issuedQ <= issue;
      end
      assign tapIssued = issuedQ;
    end else begin : gen_shift
      logic [LATENCY-1:0] issuedQ;
      always_ff @(posedge clk) begin
        if (rst) issuedQ <= '0;
        else     issuedQ <= {issuedQ[LATENCY-2:0], issue};
      end
      assign tapIssued = issuedQ[LATENCY-1];
    end
  endgenerate

  // A tracked read that comes back without data was rejected by the FIFO.
  assign releaseCredit  = tapIssued && !dataValid;
  assign unmatchedValid = dataValid && !tapIssued;

endmodule

// File: rtl/fast_fifo_stream_reader.sv
// Credit-based adapter from FastFIFO's fixed-latency read port to a ready/valid stream.
// Optional macro READER_PROTOCOL_CHECK_EN enables the sticky protocolError checks.
module fast_fifo_stream_reader
  import fast_fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH          = 20,
  parameter int READ_LATENCY   = 2,
  parameter int BUF_DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifoEmpty,
  output logic             fifoReadRequest,
  input  logic [WIDTH-1:0] fifoDataIn,
  input  logic             fifoDataValid,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataOutValid,
  input  logic             dataOutReady,
  output logic             protocolError
);

  localparam int DEPTH    = 1 << BUF_DEPTH_LOG2;
  localparam int CREDIT_W = READER_CREDIT_W(BUF_DEPTH_LOG2);
  localparam int OCC_W    = CREDIT_W + 1;
  localparam int PTR_W    = BUF_DEPTH_LOG2;

  logic [CREDIT_W-1:0] credits;
  logic [CREDIT_W-1:0] creditsNext;
  logic [OCC_W-1:0]    creditSum;
  logic [OCC_W-1:0]    occupancy;
  logic [CREDIT_W-1:0] memCount;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic tapIssued;
  logic releaseCredit;
  logic unmatchedValid;
  readerEvents_t ev;

  // Combinational so the FIFO sees the request in the same cycle it samples empty.
  assign fifoReadRequest = !rst && !fifoEmpty && (credits != '0);

  read_inflight_tracker #(
    .LATENCY(READ_LATENCY)
  ) u_tracker (
    .clk           (clk),
    .rst           (rst),
    .issue         (fifoReadRequest),
    .dataValid     (fifoDataValid),
    .tapIssued     (tapIssued),
    .releaseCredit (releaseCredit),
    .unmatchedValid(unmatchedValid)
  );

  always_comb begin : eventDecode
    ev        = '0;
    occupancy = {1'b0, memCount} + OCC_W'(dataOutValid);
    ev.request  = fifoReadRequest;
    ev.transfer = dataOutValid && dataOutReady;
    ev.slotFree = !dataOutValid || dataOutReady;
    ev.bufFull  = (occupancy >= OCC_W'(DEPTH)) && !ev.transfer;
`ifdef READER_PROTOCOL_CHECK_EN
    ev.drop = fifoDataValid && (unmatchedValid || ev.bufFull);
`endif
    ev.write    = fifoDataValid && !ev.drop;
    // With nothing queued ahead, a fresh word goes straight into the output register.
    ev.bypass   = ev.write && (memCount == '0) && ev.slotFree;
    ev.memWrite = ev.write && !ev.bypass;
    ev.memLoad  = ev.slotFree && (memCount != '0);
    // A dropped word that held a reservation must give the reservation back.
    ev.creditRelease = releaseCredit || (ev.drop && tapIssued);
  end

  always_comb begin : creditUpdate
    creditSum = {1'b0, credits} + OCC_W'(ev.creditRelease) + OCC_W'(ev.transfer)
              - OCC_W'(ev.request);
    creditsNext = creditSum[CREDIT_W-1:0];
    if (creditSum > OCC_W'(DEPTH)) creditsNext = CREDIT_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (ev.memWrite) mem[tail] <= fifoDataIn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits      <= CREDIT_W'(DEPTH);
      memCount     <= '0;
      head         <= '0;
      tail         <= '0;
      dataOut      <= '0;
      dataOutValid <= 1'b0;
    end else begin
      credits  <= creditsNext;
      memCount <= memCount + CREDIT_W'(ev.memWrite) - CREDIT_W'(ev.memLoad);
      if (ev.memWrite) tail <= tail + PTR_W'(1);
      if (ev.memLoad) begin
        dataOut      <= mem[head];
        dataOutValid <= 1'b1;
        head         <= head + PTR_W'(1);
      end else if (ev.bypass) begin
        dataOut      <= fifoDataIn;
        dataOutValid <= 1'b1;
      end else if (ev.transfer) begin
        dataOutValid <= 1'b0;
      end
    end
  end

`ifdef READER_PROTOCOL_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)          protocolError <= 1'b0;
    else if (ev.drop) protocolError <= 1'b1;
  end
`else
  logic unusedUnmatched;
  assign unusedUnmatched = unmatchedValid;
  assign protocolError   = 1'b0;
`endif

endmodule

// File: tb/tb_fast_fifo_stream_reader.sv
// Directed bench for fast_fifo_stream_reader: a fixed-latency FIFO model feeds the DUT
// and a scoreboard checks stream order; each scenario task adds its own checks.
module tb_fast_fifo_stream_reader;

  localparam int WIDTH = 20;
  localparam int RL    = 2;
  localparam int BDL   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifoEmpty;
  logic             fifoReadRequest;
  logic [WIDTH-1:0] fifoDataIn;
  logic             fifoDataValid;
  logic [WIDTH-1:0] dataOut;
  logic             dataOutValid;
  logic             dataOutReady;
  logic             protocolError;

  always #5 clk = ~clk;

  fast_fifo_stream_reader #(
    .WIDTH(WIDTH), .READ_LATENCY(RL), .BUF_DEPTH_LOG2(BDL)
  ) dut (
    .clk(clk), .rst(rst), .fifoEmpty(fifoEmpty), .fifoReadRequest(fifoReadRequest),
    .fifoDataIn(fifoDataIn), .fifoDataValid(fifoDataValid), .dataOut(dataOut),
    .dataOutValid(dataOutValid), .dataOutReady(dataOutReady), .protocolError(protocolError)
  );

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  logic             pipe_v[RL];
  logic [WIDTH-1:0] pipe_d[RL];
  logic             force_empty = 1'b1;
  logic             model_reject = 1'b0;
  logic             inject_pending = 1'b0;
  logic [WIDTH-1:0] inject_data = '0;
  logic             req_seen = 1'b0;
  logic [WIDTH-1:0] exp_word;

  int n_cmp = 0, n_fail = 0;
  int cycle = 0, req_count = 0, valid_count = 0;
  int first_req = -1, first_valid = -1, last_xfer = -1;

  // FIFO model: request sampled mid-cycle, data returns RL cycles later.
  always @(posedge clk) begin
    #2;
    for (int i = RL - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    if (req_seen && !model_reject && fifo_q.size() > 0) begin
      pipe_v[0] = 1'b1;
      pipe_d[0] = fifo_q.pop_front();
    end else begin
      pipe_v[0] = 1'b0;
      pipe_d[0] = '0;
    end
    fifoDataValid = pipe_v[RL-1];
    fifoDataIn    = pipe_d[RL-1];
    if (inject_pending) begin
      fifoDataValid  = 1'b1;
      fifoDataIn     = inject_data;
      inject_pending = 1'b0;
    end
    fifoEmpty = force_empty || (fifo_q.size() == 0);
  end

  // Monitor and scoreboard.
  always @(negedge clk) begin
    cycle++;
    req_seen = fifoReadRequest;
    if (fifoReadRequest) begin
      req_count++;
      if (first_req < 0) first_req = cycle;
    end
    if (dataOutValid) begin
      valid_count++;
      if (first_valid < 0) first_valid = cycle;
    end
    if (dataOutValid && dataOutReady && !rst) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got %h, required no transfer", dataOut);
      end else begin
        exp_word = exp_q.pop_front();
        if (dataOut !== exp_word) begin
          n_fail++;
          $display("FAIL sb_data: got %h, required %h", dataOut, exp_word);
        end
        last_xfer = cycle;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dataOutReady = 1'b0;
    force_empty = 1'b1;
    model_reject = 1'b0;
    tick(3);
    fifo_q.delete();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dataOutReady = 1'b0;
    fifo_q.push_back(20'h12345);
    force_empty = 1'b0;
    tick(3);
    n_cmp++; if (fifoReadRequest !== 1'b0) begin n_fail++; $display("FAIL rst_request: got %b, required 0", fifoReadRequest); end
    n_cmp++; if (dataOutValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", dataOutValid); end
    n_cmp++; if (dataOut !== '0) begin n_fail++; $display("FAIL rst_data: got %h, required 0", dataOut); end
    n_cmp++; if (protocolError !== 1'b0) begin n_fail++; $display("FAIL rst_perr: got %b, required 0", protocolError); end
    fifo_q.delete();
    force_empty = 1'b1;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_stream();
    bit ok;
    int base;
    do_reset();
    first_req = -1; first_valid = -1; last_xfer = -1;
    base = req_count;
    dataOutReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      fifo_q.push_back(WIDTH'(i));
      exp_q.push_back(WIDTH'(i));
    end
    force_empty = 1'b0;
    wait_drain(60, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL stream_drain: got %0d left, required 0", exp_q.size()); end
    n_cmp++; if (first_valid - first_req !== 3) begin n_fail++; $display("FAIL stream_latency: got %0d, required 3", first_valid - first_req); end
    n_cmp++; if (last_xfer - first_valid !== 7) begin n_fail++; $display("FAIL stream_rate: got %0d, required 7", last_xfer - first_valid); end
    n_cmp++; if (req_count - base !== 8) begin n_fail++; $display("FAIL stream_reqs: got %0d, required 8", req_count - base); end
  endtask

  task automatic test_stall();
    bit ok;
    int base, unstable, seen;
    do_reset();
    base = req_count; unstable = 0; seen = 0;
    for (int i = 1; i <= 8; i++) begin
      fifo_q.push_back(WIDTH'(i));
      exp_q.push_back(WIDTH'(i));
    end
    force_empty = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (dataOutValid) begin
        seen++;
        if (dataOut !== 20'h1) unstable++;
      end
    end
    n_cmp++; if (req_count - base !== 4) begin n_fail++; $display("FAIL stall_reqs: got %0d, required 4", req_count - base); end
    n_cmp++; if (fifoReadRequest !== 1'b0) begin n_fail++; $display("FAIL stall_request: got %b, required 0", fifoReadRequest); end
    n_cmp++; if (dataOutValid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b, required 1", dataOutValid); end
    n_cmp++; if (dataOut !== 20'h1) begin n_fail++; $display("FAIL stall_data: got %h, required 00001", dataOut); end
    n_cmp++; if (unstable !== 0 || seen < 15) begin n_fail++; $display("FAIL stall_hold: got %0d changes in %0d valid cycles, required 0 in >=15", unstable, seen); end
    dataOutReady = 1'b1;
    wait_drain(60, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_drain: got %0d left, required 0", exp_q.size()); end
    n_cmp++; if (req_count - base !== 8) begin n_fail++; $display("FAIL stall_total_reqs: got %0d, required 8", req_count - base); end
  endtask

  task automatic test_empty_toggle();
    bit ok;
    int base;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      fifo_q.push_back(WIDTH'(20'h100 + i * 7));
      exp_q.push_back(WIDTH'(20'h100 + i * 7));
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      force_empty = (i % 2) == 1;
      dataOutReady = 1'($urandom_range(0, 1));
      tick(1);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL toggle_drain: got %0d left, required 0", exp_q.size()); end
    tick(3);
    dataOutReady = 1'b0;
    force_empty = 1'b0;
    base = req_count;
    for (int i = 0; i < 6; i++) begin
      fifo_q.push_back(WIDTH'(20'h300 + i));
      exp_q.push_back(WIDTH'(20'h300 + i));
    end
    tick(12);
    n_cmp++; if (req_count - base !== 4) begin n_fail++; $display("FAIL toggle_credits: got %0d, required 4", req_count - base); end
    dataOutReady = 1'b1;
    wait_drain(60, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL toggle_final_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reject();
    bit ok;
    int base, vbase;
    do_reset();
    model_reject = 1'b1;
    dataOutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(WIDTH'(20'h700 + i));
      exp_q.push_back(WIDTH'(20'h700 + i));
    end
    force_empty = 1'b0;
    base = req_count;
    vbase = valid_count;
    tick(10);
    force_empty = 1'b1;
    tick(4);
    n_cmp++; if (req_count - base !== 10) begin n_fail++; $display("FAIL reject_reqs: got %0d, required 10", req_count - base); end
    n_cmp++; if (valid_count - vbase !== 0) begin n_fail++; $display("FAIL reject_output: got %0d valid cycles, required 0", valid_count - vbase); end
    model_reject = 1'b0;
    dataOutReady = 1'b0;
    force_empty = 1'b0;
    base = req_count;
    tick(12);
    n_cmp++; if (req_count - base !== 4) begin n_fail++; $display("FAIL reject_credits: got %0d, required 4", req_count - base); end
    dataOutReady = 1'b1;
    wait_drain(40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL reject_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midop();
    bit ok;
    do_reset();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(WIDTH'(20'hF00 + i));
    force_empty = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    n_cmp++; if (dataOutValid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", dataOutValid); end
    n_cmp++; if (fifoReadRequest !== 1'b0) begin n_fail++; $display("FAIL midrst_request: got %b, required 0", fifoReadRequest); end
    tick(2);
    fifo_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(WIDTH'(20'hA00 + i));
      exp_q.push_back(WIDTH'(20'hA00 + i));
    end
    dataOutReady = 1'b1;
    wait_drain(40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL midrst_drain: got %0d left, required 0", exp_q.size()); end
    tick(4);
  endtask

  task automatic test_protocol();
    bit ok;
    do_reset();
    inject_data = 20'h5A5A5;
    inject_pending = 1'b1;
    tick(1);
`ifdef READER_PROTOCOL_CHECK_EN
    n_cmp++; if (protocolError !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b, required 1", protocolError); end
    n_cmp++; if (dataOutValid !== 1'b0) begin n_fail++; $display("FAIL perr_drop: got %b, required 0", dataOutValid); end
    tick(5);
    n_cmp++; if (protocolError !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b, required 1", protocolError); end
    do_reset();
    tick(1);
    n_cmp++; if (protocolError !== 1'b0) begin n_fail++; $display("FAIL perr_clear: got %b, required 0", protocolError); end
`else
    n_cmp++; if (protocolError !== 1'b0) begin n_fail++; $display("FAIL perr_tied: got %b, required 0", protocolError); end
    n_cmp++; if (dataOutValid !== 1'b1 || dataOut !== 20'h5A5A5) begin n_fail++; $display("FAIL perr_passthru: got %b/%h, required 1/5a5a5", dataOutValid, dataOut); end
    tick(5);
    n_cmp++; if (protocolError !== 1'b0) begin n_fail++; $display("FAIL perr_tied_late: got %b, required 0", protocolError); end
    exp_q.push_back(20'h5A5A5);
    dataOutReady = 1'b1;
    wait_drain(10, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL perr_drain: got %0d left, required 0", exp_q.size()); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    fifoEmpty = 1'b1;
    fifoDataValid = 1'b0;
    fifoDataIn = '0;
    dataOutReady = 1'b0;
    for (int i = 0; i < RL; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    test_reset();
    test_stream();
    test_stall();
    test_empty_toggle();
    test_reject();
    test_reset_midop();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no completion, required finish before 400000");
    $fatal(1, "simulation time limit");
  end

endmodule
